// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default fp16 format constants, operand
// classes, flag bit positions and a classification helper.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 5;
  localparam int unsigned DEF_MAN_W = 10;
  localparam int unsigned W         = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
  localparam logic [W-1:0] NAN_CANON =
    {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  // Subnormals (exp == 0, frac != 0) are classed as zero.
  function automatic fp_cls_e classify(input logic exp_zero, input logic exp_ones,
                                       input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round_pack.sv
// Combinational normalise / round-to-nearest-even / pack stage with
// overflow-to-Inf and flush-to-zero underflow handling.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  output logic [EXP_W+MAN_W:0]     word_o,
  output logic [3:0]               flags_o
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 3;

  logic [PW-1:0]      norm;
  logic [EW-1:0]      exp_n;
  logic [EW-1:0]      exp_f;
  logic               guard;
  logic               sticky;
  logic               rnd_up;
  logic [MAN_W+1:0]   mant_r;
  logic [MAN_W-1:0]   frac;
  logic               ovf;
  logic               unf;

  // Normalise so the leading one sits at the product MSB, round, then pack.
  always_comb begin
    norm   = prod_i[PW-1] ? prod_i : (prod_i << 1);
    exp_n  = EW'(exp_i) + EW'(prod_i[PW-1]);
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd_up = guard & (sticky | norm[MAN_W+1]);
    mant_r = {1'b0, norm[PW-1:MAN_W+1]} + (MAN_W+2)'(rnd_up);
    exp_f  = exp_n + EW'(mant_r[MAN_W+1]);
    frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    // exp_f is two's complement; test sign bit first to keep compares unsigned
    ovf    = ~exp_f[EW-1] & (exp_f >= EW'((1 << EXP_W) - 1));
    unf    = exp_f[EW-1] | (exp_f == '0);

    flags_o = '0;
    word_o  = {sign_i, exp_f[EXP_W-1:0], frac};
    flags_o[FLG_INX] = guard | sticky;
    if (ovf) begin
      word_o           = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLG_OVF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else if (unf) begin
      word_o           = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UNF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// S1 classifies and resolves special cases, S2 multiplies mantissas,
// S3 rounds and packs into the output register.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int unsigned WW     = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS_L = (1 << (EXP_W - 1)) - 1;
  localparam logic [WW-1:0] NAN_L = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic                    sign;
    logic                    spec;
    logic [WW-1:0]           spec_word;
    logic [3:0]              spec_flags;
    logic signed [EXP_W+1:0] exp;
  } meta_t;

  fp_cls_e              cls_a, cls_b;
  logic                 snan;
  logic                 stall;
  meta_t                meta_d, meta1_q, meta2_q;
  logic [MAN_W:0]       ma_d, mb_d, ma_q, mb_q;
  logic [2*MAN_W+1:0]   prod_d, prod_q;
  logic                 v1_q, v2_q, v3_q;
  logic [WW-1:0]        rp_word, res_d, out_q;
  logic [3:0]           rp_flags, flg_d, flags_q;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign_i  (meta2_q.sign),
    .exp_i   (meta2_q.exp),
    .prod_i  (prod_q),
    .word_o  (rp_word),
    .flags_o (rp_flags)
  );

  // Handshake, operand classification, special-case resolution and S3 select.
  always_comb begin
    stall    = v3_q & ~out_ready;
    in_ready = ~stall;

    cls_a = classify(A[WW-2 -: EXP_W] == '0, A[WW-2 -: EXP_W] == '1, A[MAN_W-1:0] == '0);
    cls_b = classify(B[WW-2 -: EXP_W] == '0, B[WW-2 -: EXP_W] == '1, B[MAN_W-1:0] == '0);
    snan  = (cls_a == CLS_NAN && !A[MAN_W-1]) || (cls_b == CLS_NAN && !B[MAN_W-1]);

    meta_d            = '0;
    meta_d.sign       = A[WW-1] ^ B[WW-1];
    meta_d.exp        = {2'b00, A[WW-2 -: EXP_W]} + {2'b00, B[WW-2 -: EXP_W]}
                        - (EXP_W+2)'(BIAS_L);
    ma_d              = {cls_a == CLS_NORM, A[MAN_W-1:0]};
    mb_d              = {cls_b == CLS_NORM, B[MAN_W-1:0]};

    // Priority: NaN / Inf*0, then Inf, then zero.
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      meta_d.spec                = 1'b1;
      meta_d.spec_word           = NAN_L;
      meta_d.spec_flags[FLG_INV] = snan || (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                                   (cls_a == CLS_ZERO && cls_b == CLS_INF);
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      meta_d.spec      = 1'b1;
      meta_d.spec_word = {meta_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      meta_d.spec      = 1'b1;
      meta_d.spec_word = {meta_d.sign, {(EXP_W+MAN_W){1'b0}}};
    end

    prod_d = (2*MAN_W+2)'(ma_q) * (2*MAN_W+2)'(mb_q);

    // Bubbles load zero so out/flags read 0 whenever out_valid is low.
    res_d = '0;
    flg_d = '0;
    if (v2_q) begin
      res_d = meta2_q.spec ? meta2_q.spec_word  : rp_word;
      flg_d = meta2_q.spec ? meta2_q.spec_flags : rp_flags;
    end
  end

  // Pipeline registers: all stages advance together unless the output stalls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      meta1_q <= '0;
      meta2_q <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (!stall) begin
      v1_q    <= in_valid;
      meta1_q <= meta_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      v2_q    <= v1_q;
      meta2_q <= meta1_q;
      prod_q  <= prod_d;
      v3_q    <= v2_q;
      out_q   <= res_d;
      flags_q <= flg_d;
    end
  end

  assign out_valid = v3_q;
  assign out       = out_q;
  assign flags     = flags_q;

endmodule
